// File: rtl/data_bus_ctrl_pkg.sv
// rtl/data_bus_ctrl_pkg.sv - shared constants and byte-merge helper for the data bus controller
package data_bus_ctrl_pkg;

  // Upper address half that selects the configuration region
  localparam logic [15:0] CONF_HI = 16'hBFAF;

  // Word offsets inside the configuration region
  localparam logic [15:0] LED_OFF    = 16'hF000;
  localparam logic [15:0] LEDRG0_OFF = 16'hF004;
  localparam logic [15:0] LEDRG1_OFF = 16'hF008;
  localparam logic [15:0] NUM_OFF    = 16'hF010;
  localparam logic [15:0] SW_OFF     = 16'hF020;
  localparam logic [15:0] TIMER_OFF  = 16'hE000;
  localparam logic [15:0] TCMP_OFF   = 16'hE004;
  localparam logic [15:0] TCTRL_OFF  = 16'hE008;

  // TIMER_CTRL bit positions
  localparam int TCTRL_EN_BIT   = 0;
  localparam int TCTRL_PEND_BIT = 1;

  // Replace the bytes of old_v selected by be with the matching bytes of new_v
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_bus_ctrl_conf_timer.sv
// rtl/data_bus_ctrl_conf_timer.sv - free-running timer with compare and sticky pending interrupt
module data_bus_ctrl_conf_timer
  import data_bus_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        timer_we_i,
  input  logic        cmp_we_i,
  input  logic        ctrl_we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] timer_o,
  output logic [31:0] cmp_o,
  output logic [31:0] ctrl_o,
  output logic        irq_o
);

  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;
  logic        match;
  logic        clr;

  // Next-state: CPU write beats increment; compare set beats a W1C clear
  always_comb begin
    timer_d = timer_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    match   = en_q && (timer_q == cmp_q);
    clr     = ctrl_we_i && be_i[0] && wdata_i[TCTRL_PEND_BIT];

    if (timer_we_i)  timer_d = apply_be(timer_q, wdata_i, be_i);
    else if (en_q)   timer_d = timer_q + 32'd1;

    if (cmp_we_i)    cmp_d = apply_be(cmp_q, wdata_i, be_i);

    if (ctrl_we_i && be_i[0]) en_d = wdata_i[TCTRL_EN_BIT];

    if (match)       pend_d = 1'b1;
    else if (clr)    pend_d = 1'b0;
  end

  // Timer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
    end
  end

  // Control word view for register reads
  always_comb begin
    ctrl_o                 = '0;
    ctrl_o[TCTRL_EN_BIT]   = en_q;
    ctrl_o[TCTRL_PEND_BIT] = pend_q;
  end

  assign timer_o = timer_q;
  assign cmp_o   = cmp_q;
  assign irq_o   = pend_q;

endmodule

// File: rtl/data_bus_ctrl.sv
// rtl/data_bus_ctrl.sv - CPU data-port decoder routing to data RAM or configuration registers
module data_bus_ctrl #(
  parameter logic [15:0] CONF_HI = data_bus_ctrl_pkg::CONF_HI,
  parameter int          SW_W    = 8,
  parameter int          LED_W   = 16
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic [31:0]      daddr,
  input  logic             dce,
  input  logic [3:0]       we,
  input  logic [31:0]      din,
  output logic [31:0]      dm,
  output logic             ram_en,
  output logic [3:0]       ram_we,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  input  logic [SW_W-1:0]  switch_i,
  output logic [LED_W-1:0] led_o,
  output logic [1:0]       led_rg0_o,
  output logic [1:0]       led_rg1_o,
  output logic [31:0]      num_o,
  output logic             timer_int
);
  import data_bus_ctrl_pkg::*;

  logic              hit, wr_hit, rd_hit;
  logic [15:0]       off;
  logic [LED_W-1:0]  led_q, led_d;
  logic [1:0]        rg0_q, rg0_d;
  logic [1:0]        rg1_q, rg1_d;
  logic [31:0]       num_q, num_d;
  logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
  logic              sel_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rd_val;
  logic [31:0]       timer_v, cmp_v, ctrl_v;

  // Address decode; RAM side is a straight passthrough gated by the miss
  always_comb begin
    hit       = dce && (daddr[31:16] == CONF_HI);
    wr_hit    = hit && (we != 4'b0000);
    rd_hit    = hit && (we == 4'b0000);
    off       = {daddr[15:2], 2'b00};
    ram_en    = dce && !hit;
    ram_we    = we & {4{dce && !hit}};
    ram_addr  = daddr;
    ram_wdata = din;
  end

  // Byte-enabled next values for the plain output registers
  always_comb begin
    led_d = led_q;
    rg0_d = rg0_q;
    rg1_d = rg1_q;
    num_d = num_q;
    if (wr_hit) begin
      case (off)
        LED_OFF:    led_d = LED_W'(apply_be(32'(led_q), din, we));
        LEDRG0_OFF: rg0_d = 2'(apply_be(32'(rg0_q), din, we));
        LEDRG1_OFF: rg1_d = 2'(apply_be(32'(rg1_q), din, we));
        NUM_OFF:    num_d = apply_be(num_q, din, we);
        default:    ;
      endcase
    end
  end

  // Output registers and two-flop switch synchroniser
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      led_q   <= '0;
      rg0_q   <= '0;
      rg1_q   <= '0;
      num_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      led_q   <= led_d;
      rg0_q   <= rg0_d;
      rg1_q   <= rg1_d;
      num_q   <= num_d;
      sw_s1_q <= switch_i;
      sw_s2_q <= sw_s1_q;
    end
  end

  data_bus_ctrl_conf_timer u_timer (
    .clk_i      (cpu_clk_50M),
    .rst_ni     (cpu_rst_n),
    .timer_we_i (wr_hit && (off == TIMER_OFF)),
    .cmp_we_i   (wr_hit && (off == TCMP_OFF)),
    .ctrl_we_i  (wr_hit && (off == TCTRL_OFF)),
    .be_i       (we),
    .wdata_i    (din),
    .timer_o    (timer_v),
    .cmp_o      (cmp_v),
    .ctrl_o     (ctrl_v),
    .irq_o      (timer_int)
  );

  // Register read mux; unmapped offsets read as zero
  always_comb begin
    rd_val = '0;
    case (off)
      LED_OFF:    rd_val = 32'(led_q);
      LEDRG0_OFF: rd_val = 32'(rg0_q);
      LEDRG1_OFF: rd_val = 32'(rg1_q);
      NUM_OFF:    rd_val = num_q;
      SW_OFF:     rd_val = 32'(sw_s2_q);
      TIMER_OFF:  rd_val = timer_v;
      TCMP_OFF:   rd_val = cmp_v;
      TCTRL_OFF:  rd_val = ctrl_v;
      default:    rd_val = '0;
    endcase
  end

  // Capture register reads so they line up with the RAM's one-cycle latency
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      sel_q <= rd_hit;
      if (rd_hit) rdata_q <= rd_val;
    end
  end

  assign dm        = sel_q ? rdata_q : ram_rdata;
  assign led_o     = led_q;
  assign led_rg0_o = rg0_q;
  assign led_rg1_o = rg1_q;
  assign num_o     = num_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// tb/tb_data_bus_ctrl.sv - directed self-checking bench for data_bus_ctrl
module tb_data_bus_ctrl;

  localparam logic [31:0] A_LED   = 32'hBFAF_F000;
  localparam logic [31:0] A_RG0   = 32'hBFAF_F004;
  localparam logic [31:0] A_RG1   = 32'hBFAF_F008;
  localparam logic [31:0] A_NUM   = 32'hBFAF_F010;
  localparam logic [31:0] A_SW    = 32'hBFAF_F020;
  localparam logic [31:0] A_TIMER = 32'hBFAF_E000;
  localparam logic [31:0] A_TCMP  = 32'hBFAF_E004;
  localparam logic [31:0] A_TCTRL = 32'hBFAF_E008;
  localparam logic [31:0] A_UNMAP = 32'hBFAF_F100;
  localparam logic [31:0] A_RAM   = 32'h8000_0100;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n   = 1'b0;
  logic [31:0] daddr       = '0;
  logic        dce         = 1'b0;
  logic [3:0]  we          = '0;
  logic [31:0] din         = '0;
  logic [31:0] dm;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata   = 32'hDEAD_BEEF;
  logic [7:0]  switch_i    = '0;
  logic [15:0] led_o;
  logic [1:0]  led_rg0_o;
  logic [1:0]  led_rg1_o;
  logic [31:0] num_o;
  logic        timer_int;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[0:255];

  data_bus_ctrl dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .daddr       (daddr),
    .dce         (dce),
    .we          (we),
    .din         (din),
    .dm          (dm),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .switch_i    (switch_i),
    .led_o       (led_o),
    .led_rg0_o   (led_rg0_o),
    .led_rg1_o   (led_rg1_o),
    .num_o       (num_o),
    .timer_int   (timer_int)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  // One-cycle synchronous data RAM model
  always @(posedge cpu_clk_50M) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr[9:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic c, input logic [3:0] w, input logic [31:0] d);
    daddr = a; dce = c; we = w; din = d;
  endtask

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic idle(input int n);
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    drive(a, 1'b1, w, d);
    tick();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 1'b1, 4'h0, 32'h0);
    exp_q.push_back(exp);
    tick();
    chk(tag, dm, exp_q.pop_front());
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_dm", dm, 32'hDEAD_BEEF);
    chk("rst_led", 32'(led_o), 32'h0);
    chk("rst_rg0", 32'(led_rg0_o), 32'h0);
    chk("rst_num", num_o, 32'h0);
    chk("rst_int", 32'(timer_int), 32'h0);
    repeat (2) @(posedge cpu_clk_50M);
    #1 cpu_rst_n = 1'b1;
    idle(1);

    // RAM passthrough
    drive(A_RAM, 1'b1, 4'hF, 32'h1234_5678);
    #1;
    chk("ram_en_wr", 32'(ram_en), 32'h1);
    chk("ram_we_wr", 32'(ram_we), 32'hF);
    chk("ram_addr", ram_addr, A_RAM);
    chk("ram_wdata", ram_wdata, 32'h1234_5678);
    tick();
    rd("ram_rd", A_RAM, 32'h1234_5678);

    // LED byte write and readback
    drive(A_LED, 1'b1, 4'b0001, 32'hAABB_CCDD);
    #1;
    chk("led_ram_en", 32'(ram_en), 32'h0);
    chk("led_ram_we", 32'(ram_we), 32'h0);
    tick();
    chk("led_o", 32'(led_o), 32'h0000_00DD);
    drive(A_LED, 1'b1, 4'h0, 32'h0);
    #1;
    chk("led_rd_ram_en", 32'(ram_en), 32'h0);
    exp_q.push_back(32'h0000_00DD);
    tick();
    chk("led_rd", dm, exp_q.pop_front());

    // dce low: no register write
    drive(A_LED, 1'b0, 4'hF, 32'h0000_FFFF);
    tick();
    chk("dce0_led", 32'(led_o), 32'h0000_00DD);

    // NUM full and partial writes, read-after-write, low address bits ignored
    wr(A_NUM, 4'hF, 32'hCAFE_F00D);
    rd("num_raw", A_NUM, 32'hCAFE_F00D);
    wr(A_NUM, 4'b1000, 32'h1122_3344);
    chk("num_be", num_o, 32'h11FE_F00D);
    rd("num_lowbits", A_NUM | 32'h3, 32'h11FE_F00D);

    // Bicolour LEDs keep only their low bits
    wr(A_RG0, 4'hF, 32'hFFFF_FFFF);
    chk("rg0", 32'(led_rg0_o), 32'h3);
    wr(A_RG1, 4'h1, 32'h0000_0002);
    chk("rg1", 32'(led_rg1_o), 32'h2);
    rd("rg1_rd", A_RG1, 32'h2);

    // Unmapped offset: write ignored, reads zero
    wr(A_UNMAP, 4'hF, 32'h5555_5555);
    rd("unmap_rd", A_UNMAP, 32'h0);
    chk("unmap_num", num_o, 32'h11FE_F00D);

    // Switch synchroniser
    switch_i = 8'hA5;
    idle(3);
    rd("sw_settled", A_SW, 32'h0000_00A5);
    switch_i = 8'h3C;
    rd("sw_young", A_SW, 32'h0000_00A5);
    idle(1);
    rd("sw_new", A_SW, 32'h0000_003C);

    // Timer reset values
    rd("timer_rst", A_TIMER, 32'h0);
    rd("tcmp_rst", A_TCMP, 32'hFFFF_FFFF);
    rd("tctrl_rst", A_TCTRL, 32'h0);

    // Timer compare: CMP=10, enable, pending seen after the edge where TIMER==10
    wr(A_TCMP, 4'hF, 32'd10);
    wr(A_TCTRL, 4'hF, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      idle(1);
      chk($sformatf("int_low_%0d", i), 32'(timer_int), 32'h0);
    end
    idle(1);
    chk("int_rise", 32'(timer_int), 32'h1);
    wr(A_TCTRL, 4'h1, 32'd3);
    chk("int_cleared", 32'(timer_int), 32'h0);
    rd("timer_counting", A_TIMER, 32'd12);

    // Collisions: CPU write beats increment; compare set beats W1C clear
    wr(A_TIMER, 4'hF, 32'd5);
    rd("timer_wr_wins", A_TIMER, 32'd5);
    wr(A_TCMP, 4'hF, 32'd8);
    idle(1);
    chk("int_before_match", 32'(timer_int), 32'h0);
    wr(A_TCTRL, 4'h1, 32'd3);
    chk("set_beats_clr", 32'(timer_int), 32'h1);
    rd("tctrl_pend", A_TCTRL, 32'h3);

    // Reset mid-run with a register read in flight and a write being driven
    wr(A_LED, 4'h3, 32'h0000_FFFF);
    chk("led_ffff", 32'(led_o), 32'h0000_FFFF);
    rd("led_ffff_rd", A_LED, 32'h0000_FFFF);
    drive(A_LED, 1'b1, 4'hF, 32'h0000_1234);
    #1 cpu_rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led_o), 32'h0);
    chk("mid_rst_int", 32'(timer_int), 32'h0);
    chk("mid_rst_dm", dm, 32'h1234_5678);
    tick();
    tick();
    chk("hold_rst_led", 32'(led_o), 32'h0);
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    cpu_rst_n = 1'b1;
    idle(3);
    rd("post_rst_timer", A_TIMER, 32'h0);
    rd("post_rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd("post_rst_led", A_LED, 32'h0);
    rd("post_rst_tctrl", A_TCTRL, 32'h0);
    chk("post_rst_num", num_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
